// File: rtl/rsa_job_ctrl.sv
// RSA job controller: loads n, e and a as 32-bit words, runs the Rsa256Core, then streams the result out.
// Define RSA_JOB_WDT_EN to add a watchdog on the WAIT state (limit set by WDT_CYCLES).
module rsa_job_ctrl #(
  parameter int WDT_CYCLES = 400000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr_valid,
  input  logic [31:0]  i_wr_data,
  output logic         o_wr_ready,
  output logic         o_rd_valid,
  output logic [31:0]  o_rd_data,
  input  logic         i_rd_ready,
  input  logic         i_abort,
  output logic         o_busy,
  output logic         o_err,
  output logic         o_core_start,
  output logic [255:0] o_core_n,
  output logic [255:0] o_core_e,
  output logic [255:0] o_core_a,
  output logic         o_core_rst,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_N = 3'd1,
    S_LOAD_E = 3'd2,
    S_LOAD_A = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    S_OUT    = 3'd6
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic [2:0]   cnt_r;
  logic [2:0]   cnt_s;
  logic [255:0] n_r;
  logic [255:0] e_r;
  logic [255:0] a_r;
  logic [255:0] res_r;
  logic         rd_valid_r;
  logic         busy_r;
  logic         core_start_r;
  logic         core_rst_r;
  logic         wr_ready_s;
  logic         wr_fire_s;
  logic         rd_fire_s;
  logic         core_rst_s;
  logic         wdt_exp_s;

  if (WDT_CYCLES < 2) begin : g_wdt_cycles_check
    $error("rsa_job_ctrl: WDT_CYCLES must be at least 2");
  end

  function automatic state_t next_operand(input state_t cur);
    case (cur)
      S_LOAD_N: next_operand = S_LOAD_E;
      S_LOAD_E: next_operand = S_LOAD_A;
      default:  next_operand = S_START;
    endcase
  endfunction

  // Next-state, word counter and write-ready decode; abort overrides everything.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    wr_ready_s = 1'b0;
    core_rst_s = 1'b0;
    if (i_abort) begin
      state_s = S_IDLE;
      cnt_s   = 3'd0;
      if ((state_r == S_START) || (state_r == S_WAIT)) begin
        core_rst_s = 1'b1;
      end else begin
        core_rst_s = 1'b0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          wr_ready_s = 1'b1;
          if (i_wr_valid) begin
            state_s = S_LOAD_N;
            cnt_s   = 3'd1;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_LOAD_N, S_LOAD_E, S_LOAD_A: begin
          wr_ready_s = 1'b1;
          if (i_wr_valid) begin
            cnt_s = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              state_s = next_operand(state_r);
            end else begin
              state_s = state_r;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        S_START: state_s = S_WAIT;
        S_WAIT: begin
          // a finishing core wins over a watchdog expiry in the same cycle
          if (i_core_finished) begin
            state_s = S_OUT;
          end else if (wdt_exp_s) begin
            state_s    = S_IDLE;
            core_rst_s = 1'b1;
          end else begin
            state_s = S_WAIT;
          end
        end
        S_OUT: begin
          if (i_rd_ready) begin
            cnt_s = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              state_s = S_IDLE;
            end else begin
              state_s = S_OUT;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = 3'd0;
        end
      endcase
    end
  end

  assign wr_fire_s = i_wr_valid & wr_ready_s;
  assign rd_fire_s = (state_r == S_OUT) & i_rd_ready & ~i_abort;

  // State, counter and registered status outputs derived from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= 3'd0;
      rd_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      core_start_r <= 1'b0;
      core_rst_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      rd_valid_r   <= (state_s == S_OUT);
      busy_r       <= (state_s != S_IDLE);
      core_start_r <= (state_s == S_START);
      core_rst_r   <= core_rst_s;
    end
  end

  // Operand shift-in and result latch/shift-out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_r   <= 256'd0;
      e_r   <= 256'd0;
      a_r   <= 256'd0;
      res_r <= 256'd0;
    end else begin
      if (wr_fire_s) begin
        case (state_r)
          S_IDLE, S_LOAD_N: n_r <= {n_r[223:0], i_wr_data};
          S_LOAD_E:         e_r <= {e_r[223:0], i_wr_data};
          S_LOAD_A:         a_r <= {a_r[223:0], i_wr_data};
          default:          n_r <= n_r;
        endcase
      end
      if ((state_r == S_WAIT) && i_core_finished && !i_abort) begin
        res_r <= i_core_result;
      end else if (rd_fire_s) begin
        res_r <= {res_r[223:0], 32'd0};
      end else begin
        res_r <= res_r;
      end
    end
  end

`ifdef RSA_JOB_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  logic [WDT_W-1:0] wdt_cnt_r;
  logic             err_r;

  // WAIT-cycle counter, restarting from zero on every WAIT entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdt_cnt_r <= '0;
    end else if (state_r == S_WAIT) begin
      wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
    end else begin
      wdt_cnt_r <= '0;
    end
  end

  assign wdt_exp_s = (state_r == S_WAIT) && (wdt_cnt_r == WDT_W'(WDT_CYCLES - 1));

  // Sticky watchdog error, cleared when the next job starts loading.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_r <= 1'b0;
    end else if (wr_fire_s && (state_r == S_IDLE)) begin
      err_r <= 1'b0;
    end else if (wdt_exp_s && !i_core_finished && !i_abort) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign o_err = err_r;
`else
  assign wdt_exp_s = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_wr_ready   = wr_ready_s;
  assign o_rd_valid   = rd_valid_r;
  assign o_rd_data    = res_r[255:224];
  assign o_busy       = busy_r;
  assign o_core_start = core_start_r;
  assign o_core_rst   = core_rst_r;
  assign o_core_n     = n_r;
  assign o_core_e     = e_r;
  assign o_core_a     = a_r;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Self-checking bench for rsa_job_ctrl: random jobs, a behavioural modexp core and a word-level reference.
module tb_rsa_job_ctrl;

  logic         clk;
  logic         rst_n;
  logic         wr_valid;
  logic [31:0]  wr_data;
  logic         wr_ready;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_ready;
  logic         abort;
  logic         busy;
  logic         err;
  logic         core_start;
  logic [255:0] core_n;
  logic [255:0] core_e;
  logic [255:0] core_a;
  logic         core_rst;
  logic [255:0] core_res;
  logic         core_fin;
  logic         fin_model;
  logic         fin_force;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int start_cnt = 0;
  int rst_cnt = 0;
  int start_cyc = 0;
  int rst_cyc = 0;
  int core_lat = 5;
  bit core_hang = 1'b0;

  logic [31:0]  job_w [24];
  logic [255:0] exp_n;
  logic [255:0] exp_e;
  logic [255:0] exp_a;
  logic [255:0] exp_res;

  rsa_job_ctrl #(.WDT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
    .o_wr_ready(wr_ready), .o_rd_valid(rd_valid), .o_rd_data(rd_data), .i_rd_ready(rd_ready),
    .i_abort(abort), .o_busy(busy), .o_err(err), .o_core_start(core_start),
    .o_core_n(core_n), .o_core_e(core_e), .o_core_a(core_a), .o_core_rst(core_rst),
    .i_core_result(core_res), .i_core_finished(core_fin)
  );

  assign core_fin = fin_model | fin_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                          input logic [255:0] m);
    logic [511:0] r, x, mm;
    if (m == 256'd0) return 256'd0;
    mm = {256'd0, m};
    r  = 512'd1 % mm;
    x  = {256'd0, b} % mm;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[255:0];
  endfunction

  // pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (core_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (core_rst === 1'b1) begin
      rst_cnt <= rst_cnt + 1;
      rst_cyc <= cyc;
    end
  end

  // behavioural Rsa256Core: latches operands on start, answers after core_lat cycles
  logic         core_run = 1'b0;
  int           core_cnt = 0;
  logic [255:0] cn, ce, ca;
  always @(negedge clk) begin
    if (rst_n !== 1'b1 || core_rst === 1'b1) begin
      core_run  <= 1'b0;
      fin_model <= 1'b0;
    end else if (core_start === 1'b1) begin
      core_run  <= 1'b1;
      core_cnt  <= core_lat;
      cn <= core_n; ce <= core_e; ca <= core_a;
      fin_model <= 1'b0;
    end else if (core_run && !core_hang) begin
      if (core_cnt <= 1) begin
        fin_model <= 1'b1;
        core_res  <= modexp(ca, ce, cn);
        core_run  <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end else begin
      fin_model <= 1'b0;
    end
  end

  task automatic make_job();
    for (int i = 0; i < 24; i++) job_w[i] = $urandom;
    job_w[0] = job_w[0] | 32'h8000_0000;
    job_w[7] = job_w[7] | 32'h0000_0001;
    for (int i = 0; i < 8; i++) begin
      exp_n[255 - 32*i -: 32] = job_w[i];
      exp_e[255 - 32*i -: 32] = job_w[8 + i];
      exp_a[255 - 32*i -: 32] = job_w[16 + i];
    end
    exp_res = modexp(exp_a, exp_e, exp_n);
  endtask

  task automatic send_words(input int count, input bit gaps, output int first_cyc);
    int guard;
    bit acc;
    first_cyc = 0;
    for (int i = 0; i < count; i++) begin
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 100) begin
        @(negedge clk);
        guard++;
        if (gaps && $urandom_range(0, 3) == 0) begin
          wr_valid = 1'b0;
        end else begin
          wr_valid = 1'b1;
          wr_data  = job_w[i];
          #1;
          acc = (wr_ready === 1'b1);
          if (i == 0) first_cyc = cyc;
        end
      end
      if (!acc) begin
        total_cnt++;
        $display("FAIL send_word%0d: wr_ready=%b expected 1 within 100 cycles", i, wr_ready);
        wr_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_start(input int s0);
    int guard = 0;
    while (start_cnt == s0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++;
    if (start_cnt !== s0 + 1) $display("FAIL start_pulse: got %0d pulses expected 1", start_cnt - s0);
    else pass_cnt++;
  endtask

  task automatic read_words(input int mode);
    int idx = 0, p = 0, guard = 0;
    logic r;
    while (idx < 8 && guard < 300) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       r = 1'b1;
        1:       r = ((p % 4) == 0) || ((p % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rd_ready = r;
      if (rd_valid === 1'b1) begin
        p++;
        total_cnt++;
        if (rd_data !== exp_res[255 - 32*idx -: 32])
          $display("FAIL rd_word%0d: got %h expected %h", idx, rd_data, exp_res[255 - 32*idx -: 32]);
        else pass_cnt++;
        if (r) idx++;
      end
    end
    total_cnt++;
    if (idx != 8) $display("FAIL rd_count: got %0d words expected 8", idx);
    else pass_cnt++;
    @(negedge clk);
    rd_ready = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rd_done: rd_valid=%b busy=%b expected 0 0", rd_valid, busy);
    else pass_cnt++;
  endtask

  task automatic run_job(input int rd_mode, input bit gaps, input bit chk_lat);
    int s0, fc;
    make_job();
    s0 = start_cnt;
    send_words(24, gaps, fc);
    wait_start(s0);
    total_cnt++;
    if (core_n !== exp_n || core_e !== exp_e || core_a !== exp_a)
      $display("FAIL operands: n=%h expected %h", core_n, exp_n);
    else pass_cnt++;
    total_cnt++;
    if (wr_ready !== 1'b0) $display("FAIL wr_ready_wait: got %b expected 0", wr_ready);
    else pass_cnt++;
    if (chk_lat) begin
      total_cnt++;
      if (start_cyc - fc !== 24) $display("FAIL start_latency: got %0d expected 24", start_cyc - fc);
      else pass_cnt++;
    end
    read_words(rd_mode);
    total_cnt++;
    if (start_cnt !== s0 + 1) $display("FAIL single_start: got %0d expected 1", start_cnt - s0);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || err !== 1'b0 || core_start !== 1'b0 || core_rst !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b rd_valid=%b err=%b start=%b crst=%b expected all 0",
               busy, rd_valid, err, core_start, core_rst);
    else pass_cnt++;
    total_cnt++;
    if (core_n !== 256'd0 || core_e !== 256'd0 || core_a !== 256'd0 || rd_data !== 32'd0)
      $display("FAIL reset_data: n=%h rd_data=%h expected 0", core_n, rd_data);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (wr_ready !== 1'b1) $display("FAIL idle_wr_ready: got %b expected 1", wr_ready);
    else pass_cnt++;
    fin_force = 1'b1;
    @(negedge clk);
    fin_force = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (rd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_finished_ignored: rd_valid=%b busy=%b expected 0 0", rd_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_abort_wait();
    int s0, r0, fc;
    core_hang = 1'b1;
    make_job();
    s0 = start_cnt;
    send_words(24, 1'b0, fc);
    wait_start(s0);
    repeat (100) @(negedge clk);
    r0 = rst_cnt;
    abort = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (core_rst !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL abort_wait: core_rst=%b busy=%b rd_valid=%b expected 1 0 0", core_rst, busy, rd_valid);
    else pass_cnt++;
    abort = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (core_rst !== 1'b0 || rst_cnt !== r0 + 1)
      $display("FAIL abort_rst_pulse: core_rst=%b pulses=%0d expected 0 1", core_rst, rst_cnt - r0);
    else pass_cnt++;
    core_hang = 1'b0;
    run_job(0, 1'b0, 1'b0);
  endtask

  task automatic test_abort_load();
    int s0, r0, fc;
    make_job();
    s0 = start_cnt;
    r0 = rst_cnt;
    send_words(20, 1'b0, fc);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = job_w[20];
    abort    = 1'b1;
    #1;
    total_cnt++;
    if (wr_ready !== 1'b0) $display("FAIL abort_load_ready: got %b expected 0", wr_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_load_idle: busy=%b expected 0", busy);
    else pass_cnt++;
    abort    = 1'b0;
    wr_valid = 1'b0;
    repeat (30) @(negedge clk);
    total_cnt++;
    if (start_cnt !== s0 || rst_cnt !== r0)
      $display("FAIL abort_load_quiet: starts=%0d core_rsts=%0d expected 0 0", start_cnt - s0, rst_cnt - r0);
    else pass_cnt++;
  endtask

`ifdef RSA_JOB_WDT_EN
  task automatic test_watchdog();
    int s0, r0, fc, guard;
    core_hang = 1'b1;
    make_job();
    s0 = start_cnt;
    send_words(24, 1'b0, fc);
    wait_start(s0);
    r0 = rst_cnt;
    guard = 0;
    while (rst_cnt == r0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++;
    if (rst_cnt !== r0 + 1 || rst_cyc - start_cyc !== 17)
      $display("FAIL wdt_timing: pulses=%0d delay=%0d expected 1 17", rst_cnt - r0, rst_cyc - start_cyc);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL wdt_err: err=%b busy=%b expected 1 0", err, busy);
    else pass_cnt++;
    core_hang = 1'b0;
    r0 = rst_cnt;
    wr_valid = 1'b1;
    wr_data  = job_w[0];
    @(negedge clk);
    wr_valid = 1'b0;
    total_cnt++;
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL wdt_err_clear: err=%b busy=%b expected 0 1", err, busy);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (rst_cnt !== r0 || busy !== 1'b0)
      $display("FAIL wdt_cleanup: core_rsts=%0d busy=%b expected 0 0", rst_cnt - r0, busy);
    else pass_cnt++;
  endtask
`else
  task automatic test_no_watchdog();
    int s0, r0, fc;
    core_hang = 1'b1;
    make_job();
    s0 = start_cnt;
    send_words(24, 1'b0, fc);
    wait_start(s0);
    r0 = rst_cnt;
    repeat (60) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || err !== 1'b0 || rst_cnt !== r0 || rd_valid !== 1'b0)
      $display("FAIL no_wdt_wait: busy=%b err=%b core_rsts=%0d rd_valid=%b expected 1 0 0 0",
               busy, err, rst_cnt - r0, rd_valid);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    core_hang = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_async_reset();
    int fc;
    make_job();
    send_words(12, 1'b0, fc);
    total_cnt++;
    if (busy !== 1'b1 || core_n !== exp_n) $display("FAIL pre_reset: busy=%b n=%h expected 1 %h", busy, core_n, exp_n);
    else pass_cnt++;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || err !== 1'b0 || core_start !== 1'b0 || core_rst !== 1'b0)
      $display("FAIL async_reset_ctrl: busy=%b rd_valid=%b err=%b start=%b crst=%b expected all 0",
               busy, rd_valid, err, core_start, core_rst);
    else pass_cnt++;
    total_cnt++;
    if (core_n !== 256'd0 || core_e !== 256'd0)
      $display("FAIL async_reset_data: n=%h e=%h expected 0", core_n, core_e);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      core_lat = $urandom_range(1, 20);
      run_job(2, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0;
    abort = 1'b0; fin_force = 1'b0; fin_model = 1'b0; core_res = 256'd0;
    test_reset();
    core_lat = 5;
    run_job(0, 1'b0, 1'b1);
    run_job(1, 1'b0, 1'b0);
    test_abort_wait();
    test_abort_load();
`ifdef RSA_JOB_WDT_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rsa_job_ctrl.md
RSA_JOB_CTRL -- requirements
Module: rsa_job_ctrl

Interface
REQ-001 SHALL have parameter WDT_CYCLES, default 400000: maximum WAIT-state cycles before a watchdog abort (used only with RSA_JOB_WDT_EN).
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_wr_valid, input, 1 bit: the host offers an operand word.
REQ-005 SHALL have port i_wr_data, input, 32 bits: operand word, most-significant word first.
REQ-006 SHALL have port o_wr_ready, output, 1 bit: the controller accepts a word; a transfer occurs when i_wr_valid and o_wr_ready are both 1.
REQ-007 SHALL have port o_rd_valid, output, 1 bit: a result word is available.
REQ-008 SHALL have port o_rd_data, output, 32 bits: result word, most-significant word first.
REQ-009 SHALL have port i_rd_ready, input, 1 bit: the host takes the result word.
REQ-010 SHALL have port i_abort, input, 1 bit: synchronous job abort.
REQ-011 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port o_err, output, 1 bit: sticky flag that the watchdog expired.
REQ-013 SHALL have port o_core_start, output, 1 bit: one-cycle start pulse to the Rsa256Core.
REQ-014 SHALL have ports o_core_n, o_core_e and o_core_a, outputs, 256 bits each: modulus, exponent and base for the core.
REQ-015 SHALL have port o_core_rst, output, 1 bit: active-high, one-cycle reset pulse to the core.
REQ-016 SHALL have port i_core_result, input, 256 bits: the core result, a^e mod n.
REQ-017 SHALL have port i_core_finished, input, 1 bit: the core done flag.

Function
REQ-018 SHALL use the states IDLE, LOAD_N, LOAD_E, LOAD_A, START, WAIT and OUT, with a 3-bit word counter.
REQ-019 SHALL drive o_wr_ready = 1 in IDLE, LOAD_N, LOAD_E and LOAD_A when i_abort = 0, and 0 otherwise.
REQ-020 SHALL store each accepted word by shifting the target register left by 32 and inserting the word at bits [31:0]; after 8 words, word 0 occupies bits [255:224].
REQ-021 SHALL, on a transfer in IDLE, store n word 0, clear o_err, set the counter to 1 and enter LOAD_N.
REQ-022 SHALL move LOAD_N to LOAD_E, and LOAD_E to LOAD_A, when the 8th word of that operand is accepted (counter wraps 7 to 0).
REQ-023 SHALL enter START after the 8th word of a is accepted.
REQ-024 SHALL drive o_core_start = 1 for exactly the one START cycle, then enter WAIT.
REQ-025 SHALL hold o_core_n, o_core_e and o_core_a stable from START until OUT is left.
REQ-026 SHALL, on i_core_finished = 1 in WAIT, latch i_core_result into the output register and enter OUT; o_rd_valid rises the next cycle.
REQ-027 SHALL, in OUT, drive o_rd_valid = 1 with o_rd_data = register bits [255:224], and shift the register left by 32 on each read handshake.
REQ-028 SHALL return to IDLE after the 8th read handshake, with o_rd_valid low in the following cycle.
REQ-029 SHALL ignore i_core_finished outside WAIT.
REQ-030 SHALL ignore i_wr_valid outside the load states.
REQ-031 SHALL, on i_abort = 1 in any state, enter IDLE next cycle, clear the counter and drop o_rd_valid; abort has priority over a simultaneous handshake or i_core_finished.
REQ-032 SHALL pulse o_core_rst for one cycle when an abort occurs in START or WAIT.
REQ-033 SHALL have a total latency of 24 write cycles + 1 START cycle + core time + 1 latch cycle + 8 read cycles when there is no backpressure.

Reset
REQ-034 SHALL, on i_rst_n = 0, immediately force state IDLE, counter 0, o_rd_valid 0, o_core_start 0, o_core_rst 0, o_err 0, o_busy 0, operand registers 0 and result register 0.
REQ-035 SHALL leave the core reset to the system when i_rst_n is asserted; o_core_rst is not asserted by i_rst_n.

Configuration
REQ-036 SHALL, when RSA_JOB_WDT_EN is defined, count WAIT cycles from 0 on WAIT entry; when the count reaches WDT_CYCLES-1 without i_core_finished, pulse o_core_rst for one cycle, set o_err and enter IDLE.
REQ-037 SHALL, with RSA_JOB_WDT_EN defined, give i_core_finished priority over watchdog expiry in the same cycle.
REQ-038 SHALL, when RSA_JOB_WDT_EN is undefined, contain no watchdog counter, tie o_err to 0, and wait in WAIT indefinitely.

Verification
REQ-039 SHALL cover a nominal job: n = CA3586E7...029CF831, e = B6ACE0B1...BCF46BD9, a taken from enc1.bin word-wise with i_rd_ready = 1 -> one o_core_start pulse, 8 o_rd_data words equal to the matching dec1 golden value, then o_busy = 0.
REQ-040 SHALL cover output backpressure: i_rd_ready toggling 1,0,0,1 -> o_rd_data held while not taken, no word lost or repeated, exactly 8 transfers.
REQ-041 SHALL cover abort in WAIT: i_abort pulsed 100 cycles after START -> o_core_rst = 1 for one cycle, IDLE next cycle, a following job completes correctly.
REQ-042 SHALL cover abort at the 5th a word with i_wr_valid = 1 -> the word is not accepted (o_wr_ready = 0), state IDLE, no o_core_start.
REQ-043 SHALL cover the watchdog with RSA_JOB_WDT_EN defined and WDT_CYCLES = 16, using a core model that never finishes -> o_err = 1 and o_core_rst pulsed 16 cycles after WAIT entry; o_err clears on the next accepted word.
REQ-044 SHALL cover asynchronous reset: i_rst_n driven low mid-LOAD_E between clock edges -> all outputs reach their reset values immediately.
